// File: rtl/profiler_pkg.sv
// Shared types and helpers for the stream cycle profiler: channel FSM states,
// default DONE token and the saturating increment used by every counter.
package profiler_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } prof_state_e;

    localparam logic [16:0] DONE_TOKEN_DEFAULT = 17'h10100;

    // Counters up to 64 bits share this helper; callers cast to their width.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input logic        en,
                                            input logic [63:0] max_val);
        return (en && (value < max_val)) ? value + 64'd1 : value;
    endfunction

endpackage

// File: rtl/stream_cycle_profiler_if.sv
// Tapped ready/valid bundle for NUM_CH streams; the profiler only ever listens.
interface stream_cycle_profiler_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 17
);
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH-1:0]        ch_ready;

    modport master (output ch_data, ch_valid, ch_ready);
    modport slave  (input  ch_data, ch_valid, ch_ready);
endinterface

// File: rtl/stream_profile_ch.sv
// One channel of the profiler: IDLE/RUN/DONE FSM with saturating cycle, transfer
// and (with STREAM_PROFILER_STALL_CNT_EN) stall counters.
module stream_profile_ch
    import profiler_pkg::*;
#(
    parameter int                 DATA_W     = 17,
    parameter int                 CNT_W      = 32,
    parameter logic [DATA_W-1:0]  DONE_TOKEN = DATA_W'(DONE_TOKEN_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clk_en,
    input  logic              flush,
    input  logic              cfg_en,
    input  logic              cfg_start_on_xfer,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    input  logic              ready,
    output logic [CNT_W-1:0]  cycle_count,
    output logic [CNT_W-1:0]  xfer_count,
    output logic [CNT_W-1:0]  stall_count,
    output logic              done,
    output logic              sat
);
    localparam logic [63:0] CNT_MAX = 64'({CNT_W{1'b1}});

    prof_state_e      state_p1, state_nxt;
    logic             hs, is_done, start, cnt_en;
    logic [CNT_W-1:0] cyc_p1, xfer_p1, cyc_nxt, xfer_nxt;
    logic             sat_p1, sat_nxt;

    assign hs      = valid & ready;
    assign is_done = hs && (data == DONE_TOKEN);
    assign start   = cfg_en && (cfg_start_on_xfer ? hs : valid);

    assign cyc_nxt  = CNT_W'(sat_inc(64'(cyc_p1), 1'b1, CNT_MAX));
    assign xfer_nxt = CNT_W'(sat_inc(64'(xfer_p1), hs, CNT_MAX));

    // Start and DONE on the same cycle skip RUN; that cycle is still counted.
    always_comb begin
        state_nxt = state_p1;
        cnt_en    = 1'b0;
        case (state_p1)
            IDLE: if (start) begin
                cnt_en    = 1'b1;
                state_nxt = is_done ? DONE : RUN;
            end
            RUN: begin
                cnt_en = 1'b1;
                if (is_done) state_nxt = DONE;
            end
            default: ;
        endcase
    end

`ifdef STREAM_PROFILER_STALL_CNT_EN
    logic [CNT_W-1:0] stall_p1, stall_nxt;

    assign stall_nxt = CNT_W'(sat_inc(64'(stall_p1), valid & ~ready, CNT_MAX));
    assign sat_nxt   = sat_p1 | (cyc_nxt == '1) | (xfer_nxt == '1) | (stall_nxt == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                 stall_p1 <= '0;
        else if (clk_en && flush)   stall_p1 <= '0;
        else if (clk_en && cnt_en)  stall_p1 <= stall_nxt;
    end
    assign stall_count = stall_p1;
`else
    assign sat_nxt     = sat_p1 | (cyc_nxt == '1) | (xfer_nxt == '1);
    assign stall_count = '0;
`endif

    // ---- stage p1: registered state and counters ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= IDLE;
            cyc_p1   <= '0;
            xfer_p1  <= '0;
            sat_p1   <= 1'b0;
        end else if (clk_en) begin
            if (flush) begin
                state_p1 <= IDLE;
                cyc_p1   <= '0;
                xfer_p1  <= '0;
                sat_p1   <= 1'b0;
            end else begin
                state_p1 <= state_nxt;
                if (cnt_en) begin
                    cyc_p1  <= cyc_nxt;
                    xfer_p1 <= xfer_nxt;
                    sat_p1  <= sat_nxt;
                end
            end
        end
    end

    assign cycle_count = cyc_p1;
    assign xfer_count  = xfer_p1;
    assign done        = (state_p1 == DONE);
    assign sat         = sat_p1;

endmodule

// File: rtl/stream_cycle_profiler.sv
// Passive multi-channel ready/valid profiler. Optional stall counting is built
// only when STREAM_PROFILER_STALL_CNT_EN is defined.
module stream_cycle_profiler
    import profiler_pkg::*;
#(
    parameter int                 NUM_CH     = 2,
    parameter int                 DATA_W     = 17,
    parameter int                 CNT_W      = 32,
    parameter logic [DATA_W-1:0]  DONE_TOKEN = DATA_W'(DONE_TOKEN_DEFAULT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clk_en,
    input  logic                    flush,
    input  logic                    cfg_en,
    input  logic                    cfg_start_on_xfer,
    stream_cycle_profiler_if.slave  tap,
    output logic [NUM_CH*CNT_W-1:0] cycle_count,
    output logic [NUM_CH*CNT_W-1:0] xfer_count,
    output logic [NUM_CH*CNT_W-1:0] stall_count,
    output logic [NUM_CH-1:0]       ch_done,
    output logic [NUM_CH-1:0]       ch_sat,
    output logic                    all_done
);
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        stream_profile_ch #(
            .DATA_W     (DATA_W),
            .CNT_W      (CNT_W),
            .DONE_TOKEN (DONE_TOKEN)
        ) u_ch (
            .clk               (clk),
            .rst_n             (rst_n),
            .clk_en            (clk_en),
            .flush             (flush),
            .cfg_en            (cfg_en),
            .cfg_start_on_xfer (cfg_start_on_xfer),
            .data              (tap.ch_data[g*DATA_W +: DATA_W]),
            .valid             (tap.ch_valid[g]),
            .ready             (tap.ch_ready[g]),
            .cycle_count       (cycle_count[g*CNT_W +: CNT_W]),
            .xfer_count        (xfer_count[g*CNT_W +: CNT_W]),
            .stall_count       (stall_count[g*CNT_W +: CNT_W]),
            .done              (ch_done[g]),
            .sat               (ch_sat[g])
        );
    end

    assign all_done = &ch_done;

endmodule

// File: tb/tb_stream_cycle_profiler.sv
// Directed bench for stream_cycle_profiler: a 32-bit-counter instance for the
// functional cases and a 4-bit-counter instance for saturation.
module tb_stream_cycle_profiler;
    localparam logic [16:0] TOK = 17'h10100;

    logic clk = 1'b0;
    logic rst_n, clk_en, flush, cfg_en, cfg_mode;
    int   n_cmp = 0;
    int   n_err = 0;

`ifdef STREAM_PROFILER_STALL_CNT_EN
    localparam int STALL_EXP = 4;
`else
    localparam int STALL_EXP = 0;
`endif

    stream_cycle_profiler_if #(.NUM_CH(2), .DATA_W(17)) tap ();
    stream_cycle_profiler_if #(.NUM_CH(2), .DATA_W(17)) tap4 ();

    logic [63:0] cyc, xfr, stl;
    logic [1:0]  done, sat;
    logic        all_done;
    logic [7:0]  cyc4, xfr4, stl4;
    logic [1:0]  done4, sat4;
    logic        all_done4;

    stream_cycle_profiler #(.NUM_CH(2), .DATA_W(17), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .cfg_en(cfg_en),
        .cfg_start_on_xfer(cfg_mode), .tap(tap.slave),
        .cycle_count(cyc), .xfer_count(xfr), .stall_count(stl),
        .ch_done(done), .ch_sat(sat), .all_done(all_done));

    stream_cycle_profiler #(.NUM_CH(2), .DATA_W(17), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .cfg_en(cfg_en),
        .cfg_start_on_xfer(cfg_mode), .tap(tap4.slave),
        .cycle_count(cyc4), .xfer_count(xfr4), .stall_count(stl4),
        .ch_done(done4), .ch_sat(sat4), .all_done(all_done4));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int ch, input logic v, input logic r, input logic [16:0] d);
        tap.ch_valid[ch] = v;
        tap.ch_ready[ch] = r;
        tap.ch_data[ch*17 +: 17] = d;
    endtask

    task automatic idle_all();
        tap.ch_valid = '0;  tap.ch_ready = '0;  tap.ch_data = '0;
        tap4.ch_valid = '0; tap4.ch_ready = '0; tap4.ch_data = '0;
    endtask

    task automatic do_flush();
        idle_all();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({cyc, xfr, stl, done, sat, all_done} !== '0) begin
            n_err++; $display("FAIL reset_main: got %h required 0", {cyc, xfr, stl, done, sat, all_done});
        end
        n_cmp++;
        if ({cyc4, xfr4, stl4, done4, sat4, all_done4} !== '0) begin
            n_err++; $display("FAIL reset_small: got %h required 0", {cyc4, xfr4, done4, sat4});
        end
    endtask

    task automatic test_basic_stream();
        do_flush();
        repeat (5) step();
        for (int k = 0; k < 6; k++) begin
            drive(0, 1'b1, 1'b1, (k < 5) ? 17'(k + 1) : TOK);
            step();
            if (k == 4) begin
                n_cmp++;
                if (done[0] !== 1'b0 || cyc[31:0] !== 32'd5) begin
                    n_err++; $display("FAIL basic_pre_done: done=%b cyc=%0d required done=0 cyc=5", done[0], cyc[31:0]);
                end
            end
        end
        idle_all();
        n_cmp++;
        if (cyc[31:0] !== 32'd6 || xfr[31:0] !== 32'd6 || stl[31:0] !== 32'd0 || done[0] !== 1'b1) begin
            n_err++; $display("FAIL basic_counts: cyc=%0d xfer=%0d stall=%0d done=%b required 6/6/0/1",
                              cyc[31:0], xfr[31:0], stl[31:0], done[0]);
        end
        step(); step();
        n_cmp++;
        if (cyc[31:0] !== 32'd6 || done[0] !== 1'b1 || all_done !== 1'b0 || cyc[63:32] !== 32'd0) begin
            n_err++; $display("FAIL basic_hold: cyc=%0d done=%b all=%b ch1cyc=%0d required 6/1/0/0",
                              cyc[31:0], done[0], all_done, cyc[63:32]);
        end
    endtask

    task automatic run_stall_stream();
        for (int k = 0; k < 4; k++) begin drive(1, 1'b1, 1'b0, 17'h00011); step(); end
        for (int k = 0; k < 4; k++) begin drive(1, 1'b1, 1'b1, (k < 3) ? 17'(k + 17'h11) : TOK); step(); end
        idle_all();
    endtask

    task automatic test_stall();
        cfg_mode = 1'b0;
        do_flush();
        run_stall_stream();
        n_cmp++;
        if (cyc[63:32] !== 32'd8 || xfr[63:32] !== 32'd4 || stl[63:32] !== 32'(STALL_EXP) || done[1] !== 1'b1) begin
            n_err++; $display("FAIL stall_mode0: cyc=%0d xfer=%0d stall=%0d done=%b required 8/4/%0d/1",
                              cyc[63:32], xfr[63:32], stl[63:32], done[1], STALL_EXP);
        end
        cfg_mode = 1'b1;
        do_flush();
        run_stall_stream();
        n_cmp++;
        if (cyc[63:32] !== 32'd4 || xfr[63:32] !== 32'd4 || stl[63:32] !== 32'd0 || done[1] !== 1'b1) begin
            n_err++; $display("FAIL stall_mode1: cyc=%0d xfer=%0d stall=%0d done=%b required 4/4/0/1",
                              cyc[63:32], xfr[63:32], stl[63:32], done[1]);
        end
        cfg_mode = 1'b0;
    endtask

    task automatic test_tokens();
        do_flush();
        drive(0, 1'b1, 1'b1, TOK);
        drive(1, 1'b1, 1'b1, TOK);
        step();
        idle_all();
        n_cmp++;
        if (cyc[31:0] !== 32'd1 || xfr[31:0] !== 32'd1 || stl[31:0] !== 32'd0 || done[0] !== 1'b1) begin
            n_err++; $display("FAIL first_done: cyc=%0d xfer=%0d stall=%0d done=%b required 1/1/0/1",
                              cyc[31:0], xfr[31:0], stl[31:0], done[0]);
        end
        n_cmp++;
        if (all_done !== 1'b1) begin
            n_err++; $display("FAIL all_done: got %b required 1", all_done);
        end
        do_flush();
        drive(0, 1'b1, 1'b1, 17'h00005); step();
        drive(0, 1'b1, 1'b1, 17'h10001); step();
        n_cmp++;
        if (done[0] !== 1'b0 || xfr[31:0] !== 32'd2) begin
            n_err++; $display("FAIL other_token: done=%b xfer=%0d required 0/2", done[0], xfr[31:0]);
        end
        drive(0, 1'b1, 1'b1, 17'h00006); step();
        drive(0, 1'b1, 1'b1, TOK); step();
        idle_all();
        n_cmp++;
        if (cyc[31:0] !== 32'd4 || xfr[31:0] !== 32'd4 || done[0] !== 1'b1) begin
            n_err++; $display("FAIL token_stream: cyc=%0d xfer=%0d done=%b required 4/4/1", cyc[31:0], xfr[31:0], done[0]);
        end
    endtask

    task automatic test_clk_en_flush();
        do_flush();
        drive(0, 1'b1, 1'b1, 17'h00001); step();
        drive(0, 1'b1, 1'b1, 17'h00002); step();
        clk_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'(k), 1'(~k), TOK);
            if (k == 1) flush = 1'b1;
            step();
        end
        flush = 1'b0;
        n_cmp++;
        if (cyc[31:0] !== 32'd2 || xfr[31:0] !== 32'd2 || done[0] !== 1'b0) begin
            n_err++; $display("FAIL clk_en_hold: cyc=%0d xfer=%0d done=%b required 2/2/0", cyc[31:0], xfr[31:0], done[0]);
        end
        clk_en = 1'b1;
        drive(0, 1'b1, 1'b1, TOK); step();
        idle_all();
        n_cmp++;
        if (cyc[31:0] !== 32'd3 || xfr[31:0] !== 32'd3 || done[0] !== 1'b1) begin
            n_err++; $display("FAIL clk_en_resume: cyc=%0d xfer=%0d done=%b required 3/3/1", cyc[31:0], xfr[31:0], done[0]);
        end
        do_flush();
        drive(0, 1'b1, 1'b1, 17'h00001); step();
        drive(0, 1'b1, 1'b1, 17'h00002); step();
        drive(0, 1'b1, 1'b1, TOK);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle_all();
        step();
        n_cmp++;
        if (cyc[31:0] !== 32'd0 || xfr[31:0] !== 32'd0 || done[0] !== 1'b0 || all_done !== 1'b0) begin
            n_err++; $display("FAIL flush_on_done: cyc=%0d xfer=%0d done=%b all=%b required 0/0/0/0",
                              cyc[31:0], xfr[31:0], done[0], all_done);
        end
        cfg_en = 1'b0;
        drive(0, 1'b1, 1'b1, 17'h00003); step();
        idle_all();
        cfg_en = 1'b1;
        n_cmp++;
        if (cyc[31:0] !== 32'd0 || xfr[31:0] !== 32'd0) begin
            n_err++; $display("FAIL cfg_en_idle: cyc=%0d xfer=%0d required 0/0", cyc[31:0], xfr[31:0]);
        end
    endtask

    task automatic test_saturation();
        do_flush();
        for (int k = 0; k < 20; k++) begin
            tap4.ch_valid[0] = 1'b1; tap4.ch_ready[0] = 1'b1; tap4.ch_data[16:0] = 17'(k + 1);
            step();
        end
        n_cmp++;
        if (cyc4[3:0] !== 4'd15 || xfr4[3:0] !== 4'd15 || sat4 !== 2'b01 || done4[0] !== 1'b0) begin
            n_err++; $display("FAIL saturate: cyc=%0d xfer=%0d sat=%b done=%b required 15/15/01/0",
                              cyc4[3:0], xfr4[3:0], sat4, done4[0]);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cyc4, xfr4, stl4, done4, sat4, all_done4} !== '0) begin
            n_err++; $display("FAIL async_reset: got cyc=%0d xfer=%0d sat=%b required all 0", cyc4[3:0], xfr4[3:0], sat4);
        end
        idle_all();
        #2;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b1; flush = 1'b0; cfg_en = 1'b1; cfg_mode = 1'b0;
        idle_all();
        repeat (3) step();
        test_reset();
        #2;
        rst_n = 1'b1;
        step();
        test_basic_stream();
        test_stall();
        test_tokens();
        test_clk_en_flush();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
